// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared state encodings, screen constants and BCD helper for the flappy game blocks
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PLAY = 3'b010,
    ST_LOST = 3'b100
  } state_t;

  localparam logic [9:0] FLOOR_Y    = 10'd460;
  localparam logic [9:0] DEF_BIRD_X = 10'd200;
  localparam logic [9:0] DEF_BIRD_W = 10'd20;
  localparam logic [9:0] DEF_BIRD_H = 10'd20;
  localparam logic [9:0] DEF_PIPE_W = 10'd50;
  localparam logic [9:0] DEF_GAP_H  = 10'd150;

  localparam int unsigned BCD_W = 12;
  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

  // Three-digit BCD increment with per-digit carry; holds at 999.
  function automatic logic [BCD_W-1:0] bcd_inc3(input logic [BCD_W-1:0] v);
    logic [3:0] d2, d1, d0;
    {d2, d1, d0} = v;
    if (v != BCD_MAX) begin
      if (d0 != 4'd9) begin
        d0 = d0 + 4'd1;
      end else begin
        d0 = 4'd0;
        if (d1 != 4'd9) begin
          d1 = d1 + 4'd1;
        end else begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - 3-digit saturating BCD counter with synchronous clear and increment
module bcd_counter3
  import flappy_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [BCD_W-1:0] o_count
);

  logic [BCD_W-1:0] r_count;

  // Clear wins over increment so a game restart always starts from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= bcd_inc3(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_collide.sv
// rtl/pipe_collide.sv - bird/pipe collision, game-over and BCD scoring; PIPE_COLLIDE_HISCORE_EN adds a high-score register
module pipe_collide
  import flappy_pkg::*;
#(
  parameter logic [9:0]  BIRD_X     = DEF_BIRD_X,
  parameter logic [9:0]  BIRD_W     = DEF_BIRD_W,
  parameter logic [9:0]  BIRD_H     = DEF_BIRD_H,
  parameter logic [9:0]  PIPE_W     = DEF_PIPE_W,
  parameter logic [9:0]  GAP_H      = DEF_GAP_H,
  parameter logic [9:0]  FLOOR_LIM  = FLOOR_Y,
  parameter int unsigned HIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [9:0]       PipePosX,
  input  logic [9:0]       PipePosY,
  input  logic [9:0]       BirdPosY,
  output logic             Lost,
  output logic             ScoreTick,
  output logic [BCD_W-1:0] Score,
  output logic [BCD_W-1:0] HiScore
);

  localparam logic [3:0]  HIT_MAX  = 4'(HIT_CYCLES);
  localparam logic [10:0] BIRD_X_E = {1'b0, BIRD_X};
  localparam logic [10:0] BIRD_R_E = {1'b0, BIRD_X} + {1'b0, BIRD_W};

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_hit_cnt, w_hit_nxt;
  logic [9:0]  r_prev_x;
  logic        r_tick, r_lost;

  logic [10:0] w_pipe_x, w_pipe_r, w_prev_r, w_gap_top, w_gap_bot, w_bird_top, w_bird_bot;
  logic        w_overlap, w_in_gap, w_collide, w_score_cond, w_score_evt, w_score_clr;

  // All geometry is widened to 11 bits so sums never wrap.
  assign w_pipe_x   = {1'b0, PipePosX};
  assign w_pipe_r   = {1'b0, PipePosX} + {1'b0, PIPE_W};
  assign w_prev_r   = {1'b0, r_prev_x} + {1'b0, PIPE_W};
  assign w_gap_top  = {1'b0, PipePosY};
  assign w_gap_bot  = {1'b0, PipePosY} + {1'b0, GAP_H};
  assign w_bird_top = {1'b0, BirdPosY};
  assign w_bird_bot = {1'b0, BirdPosY} + {1'b0, BIRD_H};

  assign w_overlap    = (w_pipe_x < BIRD_R_E) && (w_pipe_r > BIRD_X_E);
  assign w_in_gap     = (w_bird_top >= w_gap_top) && (w_bird_bot <= w_gap_bot);
  assign w_collide    = (w_overlap && !w_in_gap) || (w_bird_bot > {1'b0, FLOOR_LIM});
  // The PipePosX < PrevX term rejects the respawn jump from the left edge back to the right.
  assign w_score_cond = (w_prev_r >= BIRD_X_E) && (w_pipe_r < BIRD_X_E) && (PipePosX < r_prev_x);

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 4'd0;
    w_score_evt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        w_score_evt = w_score_cond;
        if (w_collide) begin
          w_hit_nxt = (r_hit_cnt >= HIT_MAX) ? HIT_MAX : r_hit_cnt + 4'd1;
        end
        if (w_hit_nxt >= HIT_MAX) w_state_nxt = ST_LOST;
      end
      ST_LOST: begin
        if (!Start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_score_clr = (w_state_nxt == ST_IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_hit_cnt <= 4'd0;
      r_prev_x  <= 10'd0;
      r_tick    <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hit_cnt <= w_hit_nxt;
      r_prev_x  <= PipePosX;
      r_tick    <= w_score_evt;
      r_lost    <= (w_state_nxt == ST_LOST);
    end
  end

  bcd_counter3 u_score (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_clr   (w_score_clr),
    .i_inc   (w_score_evt),
    .o_count (Score)
  );

  assign Lost      = r_lost;
  assign ScoreTick = r_tick;

`ifdef PIPE_COLLIDE_HISCORE_EN
  logic [BCD_W-1:0] r_hi;
  logic [BCD_W-1:0] w_final;

  // A score event on the losing cycle still counts toward the final score.
  assign w_final = w_score_evt ? bcd_inc3(Score) : Score;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hi <= '0;
    end else if (r_state == ST_PLAY && w_state_nxt == ST_LOST && w_final > r_hi) begin
      r_hi <= w_final;
    end
  end

  assign HiScore = r_hi;
`else
  assign HiScore = '0;
`endif

endmodule

// File: tb/tb_pipe_collide.sv
// tb/tb_pipe_collide.sv - scoreboard bench for pipe_collide: directed games, BCD carry/saturation, wrap, glitch and reset
module tb_pipe_collide;

`ifdef PIPE_COLLIDE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [9:0]  PipePosX, PipePosY, BirdPosY;
  logic        Lost, ScoreTick;
  logic [11:0] Score, HiScore;

  int          total = 0;
  int          bad   = 0;
  int          n_score = 0;
  logic [11:0] exp_hi = 12'h000;
  logic [11:0] exp_q[$];

  pipe_collide dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .PipePosX  (PipePosX),
    .PipePosY  (PipePosY),
    .BirdPosY  (BirdPosY),
    .Lost      (Lost),
    .ScoreTick (ScoreTick),
    .Score     (Score),
    .HiScore   (HiScore)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] to_bcd(input int n);
    return 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ScoreTick must match the oldest queued expected score.
  always @(negedge Clk) begin
    if (Reset === 1'b1 && ScoreTick === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", {20'd0, Score}, 32'hFFFF_FFFF);
      end else begin
        check("tick_score", {20'd0, Score}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic [9:0] x, input logic [9:0] by, input logic st);
    PipePosX = x;
    BirdPosY = by;
    Start    = st;
    @(posedge Clk);
    #1;
  endtask

  task automatic score_pass();
    drive(10'd151, 10'd150, 1'b1);
    if (n_score < 999) n_score++;
    exp_q.push_back(to_bcd(n_score));
    drive(10'd149, 10'd150, 1'b1);
  endtask

  task automatic lose();
    drive(10'd190, 10'd50, 1'b1);
    check("lost_after_1_hit", {31'd0, Lost}, 32'd0);
    drive(10'd190, 10'd50, 1'b1);
    check("lost_after_2_hits", {31'd0, Lost}, 32'd1);
    if (HI_EN && to_bcd(n_score) > exp_hi) exp_hi = to_bcd(n_score);
    drive(10'd190, 10'd50, 1'b1);
    check("score_frozen", {20'd0, Score}, {20'd0, to_bcd(n_score)});
    check("hiscore", {20'd0, HiScore}, {20'd0, exp_hi});
  endtask

  task automatic restart();
    drive(10'd300, 10'd150, 1'b0);
    check("idle_lost", {31'd0, Lost}, 32'd0);
    check("idle_score", {20'd0, Score}, 32'd0);
    n_score = 0;
    drive(10'd300, 10'd150, 1'b1);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0;
    PipePosX = 10'd300; PipePosY = 10'd100; BirdPosY = 10'd150;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_lost", {31'd0, Lost}, 32'd0);
    check("rst_tick", {31'd0, ScoreTick}, 32'd0);
    check("rst_score", {20'd0, Score}, 32'd0);
    check("rst_hiscore", {20'd0, HiScore}, 32'd0);
    Reset = 1'b1;
    drive(10'd300, 10'd150, 1'b0);

    // Hit above the gap: Lost on the second collision edge.
    drive(10'd190, 10'd50, 1'b1);
    check("enter_play_lost", {31'd0, Lost}, 32'd0);
    lose();

    // Safe pass through the gap: one tick at X=149.
    drive(10'd160, 10'd150, 1'b0);
    n_score = 0;
    drive(10'd160, 10'd150, 1'b1);
    for (int x = 159; x >= 129; x--) begin
      if (x == 149) begin
        n_score = 1;
        exp_q.push_back(12'h001);
      end
      drive(10'(x), 10'd150, 1'b1);
    end
    check("pass_lost", {31'd0, Lost}, 32'd0);
    check("pass_score", {20'd0, Score}, 32'h001);

    // Respawn wrap 0 -> 1000 must not score.
    drive(10'd0, 10'd150, 1'b1);
    drive(10'd1000, 10'd150, 1'b1);
    drive(10'd1000, 10'd150, 1'b1);
    check("wrap_score", {20'd0, Score}, 32'h001);

    // Single-cycle collisions are filtered.
    for (int i = 0; i < 2; i++) begin
      drive(10'd190, 10'd50, 1'b1);
      check("glitch_hit", {31'd0, Lost}, 32'd0);
      drive(10'd190, 10'd150, 1'b1);
      check("glitch_clear", {31'd0, Lost}, 32'd0);
    end

    // High-score games: lose at 7, then at 3.
    repeat (6) score_pass();
    lose();
    restart();
    repeat (3) score_pass();
    lose();

    // BCD carry 095..104 and saturation at 999.
    restart();
    repeat (95) score_pass();
    check("score_095", {20'd0, Score}, 32'h095);
    repeat (9) score_pass();
    check("score_104", {20'd0, Score}, 32'h104);
    repeat (896) score_pass();
    check("score_999", {20'd0, Score}, 32'h999);
    lose();

    // Asynchronous reset in the middle of a game.
    restart();
    repeat (2) score_pass();
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    exp_hi = 12'h000;
    check("async_rst_lost", {31'd0, Lost}, 32'd0);
    check("async_rst_tick", {31'd0, ScoreTick}, 32'd0);
    check("async_rst_score", {20'd0, Score}, 32'd0);
    check("async_rst_hiscore", {20'd0, HiScore}, 32'd0);
    #7;
    Reset = 1'b1;
    drive(10'd300, 10'd150, 1'b0);
    n_score = 0;
    drive(10'd300, 10'd150, 1'b1);
    score_pass();
    check("post_rst_score", {20'd0, Score}, 32'h001);

    @(negedge Clk);
    #1;
    check("pending_ticks", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
